mem_access_ctrl: RTL and testbench

//  Multi-cycle load/store sequencer between the MEM stage and a handshaked data-memory port.

---
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer driving a handshaked, 64-bit aligned data-memory port.
// Optional macro MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing natural alignment.
module mem_access_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_mem,
    input  logic              re_mem,
    input  logic [2:0]        memdata_width,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       st_data,
    output logic              stall,
    output logic              done,
    output logic [63:0]       ld_data,
    output logic              bus_err,
    output logic              misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_rdata
);

    localparam logic [2:0] W_D  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_H  = 3'b011;
    localparam logic [2:0] W_B  = 3'b100;
    localparam logic [2:0] W_WU = 3'b101;
    localparam logic [2:0] W_HU = 3'b110;
    localparam logic [2:0] W_BU = 3'b111;
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    // Byte offset rounded down to the natural alignment of the access size.
    function automatic logic [2:0] align_off(input logic [2:0] w, input logic [2:0] o);
        case (w)
            W_D:       return 3'b000;
            W_W, W_WU: return {o[2], 2'b00};
            W_H, W_HU: return {o[2:1], 1'b0};
            default:   return o;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] w, input logic [2:0] o);
        case (w)
            W_D:       return 8'hFF;
            W_W, W_WU: return 8'h0F << o;
            W_H, W_HU: return 8'h03 << o;
            default:   return 8'h01 << o;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [2:0] w, input logic [63:0] r);
        case (w)
            W_B:     return {{56{r[7]}}, r[7:0]};
            W_BU:    return {56'd0, r[7:0]};
            W_H:     return {{48{r[15]}}, r[15:0]};
            W_HU:    return {48'd0, r[15:0]};
            W_W:     return {{32{r[31]}}, r[31:0]};
            W_WU:    return {32'd0, r[31:0]};
            default: return r;
        endcase
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] w, input logic [2:0] o);
        case (w)
            W_D:       return o != 3'b000;
            W_W, W_WU: return o[1:0] != 2'b00;
            W_H, W_HU: return o[0];
            default:   return 1'b0;
        endcase
    endfunction
`endif

    state_t            state_q;
    logic [7:0]        tmo_cnt_q;
    logic [2:0]        width_q;
    logic [2:0]        off_q;
    logic              done_q;
    logic              bus_err_q;
    logic              misalign_q;
    logic              req_valid_q;
    logic              mem_we_q;
    logic [63:0]       ld_data_q;
    logic [63:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wmask_q;

    logic       access_d;
    logic       trap_d;
    logic [2:0] off_d;

    assign access_d = (we_mem | re_mem) && (memdata_width != 3'b000);
    assign off_d    = align_off(memdata_width, addr[2:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_d   = is_misaligned(memdata_width, addr[2:0]);
`else
    assign trap_d   = 1'b0;
`endif

    assign stall = ((state_q == S_IDLE) && access_d) || (state_q == S_REQ) || (state_q == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmo_cnt_q   <= '0;
            width_q     <= '0;
            off_q       <= '0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
            req_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            ld_data_q   <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            wmask_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_d && trap_d) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        misalign_q <= 1'b1;
                        ld_data_q  <= '0;
                    end else if (access_d) begin
                        // Request fields are latched here so they stay stable through REQ.
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        mem_we_q    <= we_mem;
                        addr_q      <= {addr[ADDR_W-1:3], 3'b000};
                        wdata_q     <= st_data << {off_d, 3'b000};
                        wmask_q     <= we_mem ? byte_mask(memdata_width, off_d) : 8'h00;
                        width_q     <= memdata_width;
                        off_q       <= off_d;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        ld_data_q <= mem_we_q ? 64'd0 : extend(width_q, mem_rdata >> {off_q, 3'b000});
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        ld_data_q <= '0;
                        bus_err_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b0;
                    bus_err_q  <= 1'b0;
                    misalign_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done          = done_q;
    assign ld_data       = ld_data_q;
    assign bus_err       = bus_err_q;
    assign misalign      = misalign_q;
    assign mem_req_valid = req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, corner sequences, randomized traffic vs. a byte-level model.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_mem, re_mem;
    logic [2:0]  memdata_width;
    logic [63:0] addr, st_data;
    logic        stall, done, bus_err, misalign;
    logic [63:0] ld_data;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;

    int checks;
    int errors;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(64), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .we_mem(we_mem), .re_mem(re_mem), .memdata_width(memdata_width),
        .addr(addr), .st_data(st_data), .stall(stall), .done(done), .ld_data(ld_data),
        .bus_err(bus_err), .misalign(misalign), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        bit          we;
        bit          re;
        logic [2:0]  w;
        logic [63:0] addr;
        logic [63:0] st;
        logic [63:0] rdata;
        int          rd;
        int          sd;
        bit          noresp;
    } txn_t;

    typedef struct packed {
        int          done_cyc;
        bit          stall_gap;
        bit          stall_at_done;
        bit          req_seen;
        bit          we;
        bit          bus_err;
        bit          misalign;
        logic [63:0] ld;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } obs_t;

    typedef struct packed {
        logic [63:0] ld;
        logic [63:0] wd;
        logic [63:0] ma;
        logic [7:0]  mask;
        bit          mis;
        bit          berr;
        int          dcyc;
    } exp_t;

    typedef struct packed {
        bit          we;
        bit          re;
        logic [2:0]  w;
        logic [63:0] addr;
        logic [63:0] st;
        logic [63:0] rdata;
        logic [63:0] eld;
        logic [63:0] eaddr;
        logic [7:0]  emask;
        logic [63:0] ewd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: access size in bytes, natural alignment, byte extraction and extension by arithmetic.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int size, off, eoff;
        bit sgn;
        logic [63:0] v, m;
        case (t.w)
            3'b001:         size = 8;
            3'b010, 3'b101: size = 4;
            3'b011, 3'b110: size = 2;
            default:        size = 1;
        endcase
        sgn  = (t.w == 3'b010) || (t.w == 3'b011) || (t.w == 3'b100);
        off  = int'(t.addr[2:0]);
        eoff = off - (off % size);
`ifdef MEM_MISALIGN_TRAP_EN
        e.mis = (off % size) != 0;
`else
        e.mis = 1'b0;
`endif
        v = t.rdata >> (8 * eoff);
        if (size < 8) begin
            m = (64'd1 << (8 * size)) - 64'd1;
            v = v & m;
            if (sgn && v[8 * size - 1]) v = v | ~m;
        end
        e.berr = t.noresp && !e.mis;
        e.ld   = (e.mis || t.we || t.noresp) ? 64'd0 : v;
        e.wd   = t.st << (8 * eoff);
        e.ma   = {t.addr[63:3], 3'b000};
        e.mask = t.we ? 8'(((1 << size) - 1) << eoff) : 8'h00;
        e.dcyc = e.mis ? 1 : 3 + t.rd + t.sd;
        return e;
    endfunction

    // Entered and left just after a rising edge with the DUT idle; plays the memory side.
    task automatic do_access(input txn_t t, output obs_t o);
        int  req_cnt, wait_cnt;
        bit  acc, resp_done;
        o = '0;
        o.done_cyc = -1;
        req_cnt = 0; wait_cnt = 0; acc = 0; resp_done = 0;
        we_mem = t.we; re_mem = t.re; memdata_width = t.w; addr = t.addr; st_data = t.st;
        for (int c = 0; c < 40; c++) begin
            mem_req_ready = mem_req_valid ? (req_cnt == t.rd) : 1'($urandom);
            if (acc && !resp_done && !mem_req_valid) begin
                mem_resp_valid = !t.noresp && (wait_cnt == t.sd);
                mem_rdata      = mem_resp_valid ? t.rdata : {$urandom, $urandom};
            end else if (!acc) begin
                mem_resp_valid = 1'($urandom);
                mem_rdata      = {$urandom, $urandom};
            end else begin
                mem_resp_valid = 1'b0;
            end
            #1;
            if (done) begin
                o.done_cyc      = c;
                o.stall_at_done = stall;
                o.ld            = ld_data;
                o.bus_err       = bus_err;
                o.misalign      = misalign;
                break;
            end
            if (!stall) o.stall_gap = 1'b1;
            if (mem_req_valid && mem_req_ready) begin
                acc = 1; o.req_seen = 1;
                o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata; o.mask = mem_wmask;
            end else if (mem_req_valid) begin
                req_cnt++;
            end else if (acc) begin
                if (mem_resp_valid) resp_done = 1;
                else wait_cnt++;
            end
            @(posedge clk); #1;
        end
        we_mem = 0; re_mem = 0; mem_req_ready = 0; mem_resp_valid = 0;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input bit we, input bit re, input logic [2:0] w, input logic [63:0] a,
                                input logic [63:0] st, input logic [63:0] rd, input logic [63:0] eld,
                                input logic [63:0] ea, input logic [7:0] em, input logic [63:0] ewd);
        vec_t v;
        v.we = we; v.re = re; v.w = w; v.addr = a; v.st = st; v.rdata = rd;
        v.eld = eld; v.eaddr = ea; v.emask = em; v.ewd = ewd;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        txn_t t;
        obs_t o;
        exp_t e;
        int   nv;

        checks = 0; errors = 0;
        rst = 1; we_mem = 0; re_mem = 0; memdata_width = 0; addr = 0; st_data = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

        vecs[0]  = mk(0, 1, 3'b100, 64'h1003, 64'h0, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, 64'h1000, 8'h00, 64'h0);
        vecs[1]  = mk(1, 0, 3'b011, 64'h2006, 64'hBEEF, 64'h0, 64'h0, 64'h2000, 8'hC0, 64'hBEEF0000_00000000);
        vecs[2]  = mk(0, 1, 3'b101, 64'h104, 64'h0, 64'h89ABCDEF_00000000, 64'h00000000_89ABCDEF, 64'h100, 8'h00, 64'h0);
        vecs[3]  = mk(0, 1, 3'b010, 64'h104, 64'h0, 64'h89ABCDEF_00000000, 64'hFFFFFFFF_89ABCDEF, 64'h100, 8'h00, 64'h0);
        vecs[4]  = mk(0, 1, 3'b001, 64'h208, 64'h0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 64'h208, 8'h00, 64'h0);
        vecs[5]  = mk(0, 1, 3'b110, 64'h30A, 64'h0, 64'h11223344_55667788, 64'h00000000_00005566, 64'h308, 8'h00, 64'h0);
        vecs[6]  = mk(0, 1, 3'b011, 64'h30C, 64'h0, 64'h11228844_55667788, 64'hFFFFFFFF_FFFF8844, 64'h308, 8'h00, 64'h0);
        vecs[7]  = mk(0, 1, 3'b111, 64'h407, 64'h0, 64'hF0000000_00000000, 64'h00000000_000000F0, 64'h400, 8'h00, 64'h0);
        vecs[8]  = mk(1, 0, 3'b001, 64'h508, 64'hDEADBEEF_CAFEF00D, 64'h0, 64'h0, 64'h508, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        vecs[9]  = mk(1, 0, 3'b010, 64'h60C, 64'h12345678_9ABCDEF0, 64'h0, 64'h0, 64'h608, 8'hF0, 64'h9ABCDEF0_00000000);
        vecs[10] = mk(1, 1, 3'b100, 64'h701, 64'h00000000_000055AB, 64'h0, 64'h0, 64'h700, 8'h02, 64'h00000000_0055AB00);
        vecs[11] = mk(0, 1, 3'b010, 64'h102, 64'h0, 64'h11111111_8BADF00D, 64'hFFFFFFFF_8BADF00D, 64'h100, 8'h00, 64'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        nv = 11;
`else
        nv = 12;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset ld_data", ld_data, 64'd0);
        chk("reset bus_err", 64'(bus_err), 64'd0);
        chk("reset misalign", 64'(misalign), 64'd0);
        chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset mem_we", 64'(mem_we), 64'd0);
        chk("reset mem_addr", mem_addr, 64'd0);
        chk("reset mem_wdata", mem_wdata, 64'd0);
        chk("reset mem_wmask", 64'(mem_wmask), 64'd0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < nv; i++) begin
            t = '0;
            t.we = vecs[i].we; t.re = vecs[i].re; t.w = vecs[i].w; t.addr = vecs[i].addr;
            t.st = vecs[i].st; t.rdata = vecs[i].rdata;
            do_access(t, o);
            chk($sformatf("vec%0d done cycle", i), 64'(o.done_cyc), 64'd3);
            chk($sformatf("vec%0d ld_data", i), o.ld, vecs[i].eld);
            chk($sformatf("vec%0d bus_err", i), 64'(o.bus_err), 64'd0);
            chk($sformatf("vec%0d stall gap", i), 64'(o.stall_gap), 64'd0);
            chk($sformatf("vec%0d stall at done", i), 64'(o.stall_at_done), 64'd0);
            chk($sformatf("vec%0d mem_we", i), 64'(o.we), 64'(vecs[i].we));
            chk($sformatf("vec%0d mem_addr", i), o.addr, vecs[i].eaddr);
            chk($sformatf("vec%0d mem_wmask", i), 64'(o.mask), 64'(vecs[i].emask));
            if (vecs[i].we) chk($sformatf("vec%0d mem_wdata", i), o.wdata, vecs[i].ewd);
        end

`ifdef MEM_MISALIGN_TRAP_EN
        t = '0; t.re = 1; t.w = 3'b010; t.addr = 64'h102; t.rdata = 64'h11111111_8BADF00D;
        do_access(t, o);
        chk("trap done cycle", 64'(o.done_cyc), 64'd1);
        chk("trap misalign", 64'(o.misalign), 64'd1);
        chk("trap ld_data", o.ld, 64'd0);
        chk("trap no request", 64'(o.req_seen), 64'd0);
`endif

        // Bus timeout: no response ever arrives.
        t = '0; t.re = 1; t.w = 3'b001; t.addr = 64'h800; t.noresp = 1;
        do_access(t, o);
        chk("tmo done seen", 64'(o.done_cyc > 2), 64'd1);
        chk("tmo bus_err", 64'(o.bus_err), 64'd1);
        chk("tmo ld_data", o.ld, 64'd0);
        chk("tmo idle stall", 64'(stall), 64'd0);
        chk("tmo idle done", 64'(done), 64'd0);
        chk("tmo idle bus_err", 64'(bus_err), 64'd0);
        chk("tmo idle req_valid", 64'(mem_req_valid), 64'd0);

        // Reset while waiting for the response; the late response must be dropped.
        re_mem = 1; memdata_width = 3'b001; addr = 64'h900; mem_req_ready = 1;
        @(posedge clk); #1;
        chk("rstwait in REQ", 64'(mem_req_valid), 64'd1);
        @(posedge clk); #1;
        chk("rstwait in WAIT stall", 64'(stall), 64'd1);
        rst = 1; mem_req_ready = 0;
        @(posedge clk); #1;
        rst = 0; re_mem = 0; mem_resp_valid = 1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        #1;
        chk("rstwait req_valid", 64'(mem_req_valid), 64'd0);
        chk("rstwait stall", 64'(stall), 64'd0);
        chk("rstwait done0", 64'(done), 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 0;
        #1;
        chk("rstwait done1", 64'(done), 64'd0);
        chk("rstwait ld_data", ld_data, 64'd0);
        chk("rstwait stall1", 64'(stall), 64'd0);
        @(posedge clk); #1;
        t = '0;
        t.we = vecs[0].we; t.re = vecs[0].re; t.w = vecs[0].w; t.addr = vecs[0].addr; t.rdata = vecs[0].rdata;
        do_access(t, o);
        chk("after reset done cycle", 64'(o.done_cyc), 64'd3);
        chk("after reset ld_data", o.ld, vecs[0].eld);

        // Width 000 is not an access.
        we_mem = 1; memdata_width = 3'b000; addr = 64'h1234;
        #1;
        chk("nowidth stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        chk("nowidth req_valid", 64'(mem_req_valid), 64'd0);
        chk("nowidth done", 64'(done), 64'd0);
        we_mem = 0;
        @(posedge clk); #1;

        for (int n = 0; n < 60; n++) begin
            t = '0;
            t.we = 1'($urandom_range(0, 1));
            t.re = t.we ? 1'($urandom_range(0, 1)) : 1'b1;
            t.w = 3'($urandom_range(1, 7));
            t.addr = {$urandom, $urandom};
            t.st = {$urandom, $urandom};
            t.rdata = {$urandom, $urandom};
            t.rd = $urandom_range(0, 3);
            t.sd = $urandom_range(0, TMO - 2);
            t.noresp = ($urandom_range(0, 9) == 0);
            e = model(t);
            do_access(t, o);
            chk($sformatf("rnd%0d done seen", n), 64'(o.done_cyc >= 0), 64'd1);
            if (!t.noresp || e.mis) chk($sformatf("rnd%0d done cycle", n), 64'(o.done_cyc), 64'(e.dcyc));
            chk($sformatf("rnd%0d ld_data", n), o.ld, e.ld);
            chk($sformatf("rnd%0d bus_err", n), 64'(o.bus_err), 64'(e.berr));
            chk($sformatf("rnd%0d misalign", n), 64'(o.misalign), 64'(e.mis));
            chk($sformatf("rnd%0d stall", n), {62'd0, o.stall_gap, o.stall_at_done}, 64'd0);
            chk($sformatf("rnd%0d req seen", n), 64'(o.req_seen), 64'(!e.mis));
            if (!e.mis) begin
                chk($sformatf("rnd%0d mem_we", n), 64'(o.we), 64'(t.we));
                chk($sformatf("rnd%0d mem_addr", n), o.addr, e.ma);
                chk($sformatf("rnd%0d mem_wmask", n), 64'(o.mask), 64'(e.mask));
                if (t.we) chk($sformatf("rnd%0d mem_wdata", n), o.wdata, e.wd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
